mem_store_seq: RTL and testbench

Store sequencer between the core's store request and the byte-wide write port of the main memory. It accepts one byte, halfword or word store per request and serialises it into consecutive single-byte writes, least-significant byte first, matching the memory's little-endian layout. The memory's combinational read path is unaffected, but the sequencer holds read enable low while it owns the port.

---
 rtl/mem_store_pkg.sv | 42 ++++
 rtl/mem_store_seq.sv | 142 ++++++++++++++
 tb/tb_mem_store_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_pkg.sv
// Shared types and helpers for the store sequencer: size encodings, FSM states,
// byte-count decode and alignment check.
package mem_store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10,
        ERR   = 2'b11
    } seq_state_e;

    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] cnt;
        case (size)
            SZ_BYTE: cnt = 3'd1;
            SZ_HALF: cnt = 3'd2;
            SZ_WORD: cnt = 3'd4;
            default: cnt = 3'd0;
        endcase
        return cnt;
    endfunction

    // Natural alignment only; the illegal size encoding is rejected separately.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_store_seq.sv
// Store sequencer: accepts one byte/half/word store and emits it as consecutive
// little-endian single-byte writes on the memory port.
module mem_store_seq
    import mem_store_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_data_i,
    input  logic [1:0]        req_size_i,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_write_en_o,
    output logic              mem_read_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    seq_state_e        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [2:0]        count_q, count_d;

    logic              hs_s;
    logic              reject_s;
    logic              last_s;
    logic [AWIDTH-1:0] idx_ext_s;
    logic [7:0]        lane_s;

    assign hs_s      = req_valid_i && (state_q == IDLE);
    assign reject_s  = (req_size_i == SZ_ILLEGAL) || is_misaligned(req_size_i, req_addr_i[1:0]);
    assign last_s    = ({1'b0, idx_q} == (count_q - 3'd1));
    assign idx_ext_s = {{(AWIDTH-2){1'b0}}, idx_q};
    assign lane_s    = data_q[{idx_q, 3'b000} +: 8];

    // State and request-capture registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            addr_q  <= {AWIDTH{1'b0}};
            data_q  <= {DWIDTH{1'b0}};
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Next-state and byte-index sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = 2'd0;
                if (hs_s) begin
                    if (reject_s) begin
                        state_d = ERR;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (last_s) begin
                    state_d = DONE;
                    idx_d   = 2'd0;
                end else begin
                    state_d = WRITE;
                    idx_d   = idx_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture happens only on the handshake; inputs are ignored afterwards.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        if (hs_s) begin
            addr_d  = req_addr_i;
            data_d  = req_data_i;
            count_d = byte_count(req_size_i);
        end else begin
            addr_d  = addr_q;
            data_d  = data_q;
            count_d = count_q;
        end
    end

    // Output decode from registered state only; address/data are zero unless writing.
    always_comb begin
        req_ready_o    = 1'b0;
        mem_addr_o     = {AWIDTH{1'b0}};
        mem_data_o     = {DWIDTH{1'b0}};
        mem_write_en_o = 1'b0;
        mem_read_en_o  = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        err_o          = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
            end
            WRITE: begin
                busy_o         = 1'b1;
                mem_write_en_o = 1'b1;
                mem_addr_o     = addr_q + idx_ext_s;
                mem_data_o     = {{(DWIDTH-8){1'b0}}, lane_s};
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            ERR: begin
                busy_o = 1'b1;
                err_o  = 1'b1;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_store_seq.sv
// Scoreboard bench for mem_store_seq: directed stores push expected writes and
// done/err pulses with their cycle; a negedge monitor pops and compares.
module tb_mem_store_seq;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [1:0]  req_size_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_write_en_o;
    logic        mem_read_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 err
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mem[logic [31:0]];
    int         cyc;
    int         n_checks;
    int         n_fail;

    mem_store_seq #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_size_i     (req_size_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_read_en_o  (mem_read_en_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] rd8(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] rd32(input logic [31:0] a);
        return {rd8(a + 32'd3), rd8(a + 32'd2), rd8(a + 32'd1), rd8(a)};
    endfunction

    task automatic exp_w(input int c, input logic [31:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = 0; e.cyc = c; e.addr = a; e.data = d;
        expq.push_back(e);
    endtask

    task automatic exp_ev(input int k, input int c);
        exp_t e;
        e.kind = k; e.cyc = c; e.addr = 32'h0; e.data = 8'h00;
        expq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the handshake edge with t = handshake cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input bit keep, output int t);
        int n;
        n = 0;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_data_i  = d;
        req_size_i  = s;
        while (!req_ready_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("handshake_wait", {63'd0, (n < 20)}, 64'd1);
        t = cyc;
        @(posedge clk);
        #1;
        if (!keep) begin
            req_valid_i = 1'b0;
        end else begin
            req_valid_i = 1'b1;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a pulse.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (mem_write_en_o || done_o || err_o) begin
            kind = mem_write_en_o ? 0 : (done_o ? 1 : 2);
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: actual kind %0d required none (cycle %0d)", kind, cyc);
            end else begin
                e = expq.pop_front();
                chk("ev_kind", kind, e.kind);
                chk("ev_cycle", cyc, e.cyc);
                if (e.kind == 0) begin
                    chk("wr_addr", mem_addr_o, e.addr);
                    chk("wr_data", mem_data_o, {24'h0, e.data});
                end
            end
            chk("ready_low_when_active", req_ready_o, 1'b0);
            chk("busy_when_active", busy_o, 1'b1);
            if (mem_write_en_o) begin
                mem[mem_addr_o] = mem_data_o[7:0];
            end
        end else begin
            chk("idle_addr_data_zero", {mem_addr_o, mem_data_o}, 64'h0);
        end
        chk("read_en_low", mem_read_en_o, 1'b0);
    end

    initial begin
        int t, t1, t2;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = 32'h0;
        req_data_i  = 32'h0;
        req_size_i  = 2'b00;
        mem[32'h0100_0000] = 8'h01;
        mem[32'h0100_0001] = 8'h02;
        mem[32'h0100_0002] = 8'h03;
        mem[32'h0100_0003] = 8'h04;
        mem[32'h0100_0005] = 8'h3C;

        step(3);
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_outputs", {mem_write_en_o, busy_o, done_o, err_o}, 4'b0000);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_data", mem_data_o, 32'h0);
        rst = 1'b0;
        step(1);

        // Word store
        issue(32'h0100_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, t);
        exp_w(t + 1, 32'h0100_0010, 8'hEF);
        exp_w(t + 2, 32'h0100_0011, 8'hBE);
        exp_w(t + 3, 32'h0100_0012, 8'hAD);
        exp_w(t + 4, 32'h0100_0013, 8'hDE);
        exp_ev(1, t + 5);
        step(6);
        chk("word_readback", rd32(32'h0100_0010), 32'hDEAD_BEEF);

        // Halfword then byte; byte 0x0100_0005 keeps its prior value
        issue(32'h0100_0006, 32'h0000_A55A, 2'b01, 1'b0, t);
        exp_w(t + 1, 32'h0100_0006, 8'h5A);
        exp_w(t + 2, 32'h0100_0007, 8'hA5);
        exp_ev(1, t + 3);
        issue(32'h0100_0004, 32'h1234_5677, 2'b00, 1'b0, t);
        exp_w(t + 1, 32'h0100_0004, 8'h77);
        exp_ev(1, t + 2);
        step(3);
        chk("half_byte_readback", rd32(32'h0100_0004), 32'hA55A_3C77);

        // Misaligned word and illegal size
        issue(32'h0100_0002, 32'hCAFE_F00D, 2'b10, 1'b0, t);
        exp_ev(2, t + 1);
        issue(32'h0100_0000, 32'hCAFE_F00D, 2'b11, 1'b0, t);
        exp_ev(2, t + 1);
        step(3);
        chk("err_mem_unchanged", rd32(32'h0100_0000), 32'h0403_0201);

        // Back-to-back bytes with valid held high
        issue(32'h0100_0030, 32'h0000_00AA, 2'b00, 1'b1, t1);
        exp_w(t1 + 1, 32'h0100_0030, 8'hAA);
        exp_ev(1, t1 + 2);
        issue(32'h0100_0031, 32'h0000_00BB, 2'b00, 1'b0, t2);
        exp_w(t2 + 1, 32'h0100_0031, 8'hBB);
        exp_ev(1, t2 + 2);
        chk("b2b_spacing", t2 - t1, 3);
        step(3);

        // Reset during the second write cycle of a word
        issue(32'h0100_0020, 32'h1122_3344, 2'b10, 1'b0, t);
        exp_w(t + 1, 32'h0100_0020, 8'h44);
        exp_w(t + 2, 32'h0100_0021, 8'h33);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_ready", req_ready_o, 1'b1);
        chk("midrst_outputs", {mem_write_en_o, busy_o, done_o, err_o}, 4'b0000);
        chk("midrst_addr_data", {mem_addr_o, mem_data_o}, 64'h0);
        step(6);
        chk("midrst_readback", rd32(32'h0100_0020), 32'h0000_3344);

        // Reset and request together: request dropped
        rst         = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0100_0040;
        req_data_i  = 32'h0000_0055;
        req_size_i  = 2'b00;
        step(1);
        rst         = 1'b0;
        req_valid_i = 1'b0;
        chk("rst_wins_idle", {req_ready_o, busy_o}, 2'b10);
        step(3);
        chk("rst_wins_no_write", rd8(32'h0100_0040), 8'h00);

        // Address wrap
        issue(32'hFFFF_FFFF, 32'h0000_005A, 2'b00, 1'b0, t);
        exp_w(t + 1, 32'hFFFF_FFFF, 8'h5A);
        exp_ev(1, t + 2);
        issue(32'hFFFF_FFFE, 32'h0000_1234, 2'b01, 1'b0, t);
        exp_w(t + 1, 32'hFFFF_FFFE, 8'h34);
        exp_w(t + 2, 32'hFFFF_FFFF, 8'h12);
        exp_ev(1, t + 3);
        step(6);

        chk("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
